// File: rtl/ip4_sm_arb.sv
// Round-robin arbiter that shares one single-port SM bank between N_REQ requesters,
// with bounded lock bursts and an RD_LAT-deep tagged response pipe.
module ip4_sm_arb #(
  parameter int N_REQ    = 4,
  parameter int ADR_W    = 10,
  parameter int DAT_W    = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arb_en,
  input  logic [N_REQ-1:0]           req_vld,
  input  logic [N_REQ-1:0]           req_wen,
  input  logic [N_REQ-1:0]           req_lock,
  input  logic [N_REQ*ADR_W-1:0]     req_adr,
  input  logic [N_REQ*DAT_W-1:0]     req_dat,
  output logic [N_REQ-1:0]           req_rdy,
  output logic                       bk_wen,
  output logic [ADR_W-1:0]           bk_adr,
  output logic [DAT_W-1:0]           bk_datai,
  input  logic [DAT_W-1:0]           bk_datao,
  output logic                       rsp_vld,
  output logic                       rsp_wr,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [DAT_W-1:0]           rsp_dat
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             lock_vld_q, lock_vld_d;
  logic [ID_W-1:0]  lock_own_q, lock_own_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic [RD_LAT-1:0]           pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0]           pipe_wr_q, pipe_wr_d;
  logic [RD_LAT-1:0][ID_W-1:0] pipe_id_q, pipe_id_d;

  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  cand;
  logic [CNT_W-1:0] base_cnt;

  // Grant selection. The reset term keeps the bank port idle while held in reset.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (rst_n && arb_en && (|req_vld)) begin
      if (lock_vld_q && req_vld[lock_own_q]) begin
        gnt_vld = 1'b1;
        gnt_idx = lock_own_q;
      end else begin
        // Walk offsets from far to near so the nearest valid requester after rr_ptr wins.
        for (int i = N_REQ; i >= 1; i--) begin
          cand = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
          if (req_vld[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
          end
        end
      end
    end
  end

  always_comb begin
    req_rdy  = '0;
    bk_wen   = 1'b0;
    bk_adr   = '0;
    bk_datai = '0;
    if (gnt_vld) begin
      req_rdy[gnt_idx] = 1'b1;
      bk_wen   = req_wen[gnt_idx];
      bk_adr   = req_adr[int'(gnt_idx)*ADR_W +: ADR_W];
      bk_datai = req_dat[int'(gnt_idx)*DAT_W +: DAT_W];
    end
  end

  // Round-robin pointer and lock bookkeeping; any cycle without a grant drops the lock.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = 1'b0;
    lock_own_d = lock_own_q;
    lock_cnt_d = '0;
    base_cnt   = '0;
    if (gnt_vld) begin
      rr_ptr_d = gnt_idx;
      if (lock_vld_q && (lock_own_q == gnt_idx)) begin
        base_cnt = lock_cnt_q;
      end
      if (req_lock[gnt_idx] && ((int'(base_cnt) + 1) < MAX_LOCK)) begin
        lock_vld_d = 1'b1;
        lock_own_d = gnt_idx;
        lock_cnt_d = base_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_wr_d     = pipe_wr_q;
    pipe_id_d     = pipe_id_q;
    pipe_vld_d[0] = gnt_vld;
    pipe_wr_d[0]  = gnt_vld & bk_wen;
    pipe_id_d[0]  = gnt_idx;
    for (int k = 1; k < RD_LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_wr_d[k]  = pipe_wr_q[k-1];
      pipe_id_d[k]  = pipe_id_q[k-1];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= ID_W'(N_REQ - 1);
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
      lock_cnt_q <= '0;
      pipe_vld_q <= '0;
      pipe_wr_q  <= '0;
      pipe_id_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_wr_q  <= pipe_wr_d;
      pipe_id_q  <= pipe_id_d;
    end
  end

  // The last pipe stage lines up with bank read data; fields are forced to 0 when idle.
  always_comb begin
    rsp_vld = pipe_vld_q[RD_LAT-1];
    rsp_wr  = 1'b0;
    rsp_id  = '0;
    rsp_dat = '0;
    if (rsp_vld) begin
      rsp_wr = pipe_wr_q[RD_LAT-1];
      rsp_id = pipe_id_q[RD_LAT-1];
      if (!pipe_wr_q[RD_LAT-1]) begin
        rsp_dat = bk_datao;
      end
    end
  end

endmodule

// File: tb/tb_ip4_sm_arb.sv
// Self-checking bench for ip4_sm_arb: table of grant vectors plus a response scoreboard
// fed from a behavioural single-port bank with RD_LAT-cycle read latency.
module tb_ip4_sm_arb;

  localparam int N_REQ    = 4;
  localparam int ADR_W    = 10;
  localparam int DAT_W    = 32;
  localparam int RD_LAT   = 2;
  localparam int MAX_LOCK = 4;

  logic                     clk;
  logic                     rst_n;
  logic                     arb_en;
  logic [N_REQ-1:0]         req_vld, req_wen, req_lock, req_rdy;
  logic [N_REQ*ADR_W-1:0]   req_adr;
  logic [N_REQ*DAT_W-1:0]   req_dat;
  logic                     bk_wen;
  logic [ADR_W-1:0]         bk_adr;
  logic [DAT_W-1:0]         bk_datai, bk_datao;
  logic                     rsp_vld, rsp_wr;
  logic [1:0]               rsp_id;
  logic [DAT_W-1:0]         rsp_dat;

  ip4_sm_arb #(
    .N_REQ(N_REQ), .ADR_W(ADR_W), .DAT_W(DAT_W), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .req_vld(req_vld), .req_wen(req_wen), .req_lock(req_lock),
    .req_adr(req_adr), .req_dat(req_dat), .req_rdy(req_rdy),
    .bk_wen(bk_wen), .bk_adr(bk_adr), .bk_datai(bk_datai), .bk_datao(bk_datao),
    .rsp_vld(rsp_vld), .rsp_wr(rsp_wr), .rsp_id(rsp_id), .rsp_dat(rsp_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural bank: captures at the edge, read data appears RD_LAT cycles later.
  bit   [DAT_W-1:0] mem [1 << ADR_W];
  logic [DAT_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (bk_wen) mem[bk_adr] <= bk_datai;
    rd_pipe[0] <= mem[bk_adr];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign bk_datao = rd_pipe[RD_LAT-1];

  typedef struct packed {
    logic             en;
    logic [3:0]       vld;
    logic [3:0]       wen;
    logic [3:0]       lock;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [3:0]       exp;
  } vec_t;

  typedef struct packed {
    int               due;
    logic             wr;
    logic [1:0]       id;
    logic [DAT_W-1:0] dat;
  } exp_rsp_t;

  vec_t       tbl[$];
  exp_rsp_t   sb[$];
  bit [DAT_W-1:0] shadow [1 << ADR_W];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic [3:0] vld, input logic [3:0] wen,
                              input logic [3:0] lock, input logic [ADR_W-1:0] adr,
                              input logic [DAT_W-1:0] dat, input logic [3:0] exp);
    vec_t v;
    v.en = en; v.vld = vld; v.wen = wen; v.lock = lock;
    v.adr = adr; v.dat = dat; v.exp = exp;
    return v;
  endfunction

  // Pops the scoreboard when a response is due, otherwise the response port must be quiet.
  task automatic mon_rsp();
    exp_rsp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rsp_vld", 64'(rsp_vld), 64'(1));
      check("rsp_wr",  64'(rsp_wr),  64'(e.wr));
      check("rsp_id",  64'(rsp_id),  64'(e.id));
      check("rsp_dat", 64'(rsp_dat), 64'(e.dat));
    end else begin
      check("rsp_idle", 64'(rsp_vld), 64'(0));
    end
  endtask

  // Non-granted requesters carry decoy address/data so a wrong mux select shows on the bank port.
  task automatic step(input vec_t v);
    int g;
    exp_rsp_t e;
    @(negedge clk);
    mon_rsp();
    arb_en   = v.en;
    req_vld  = v.vld;
    req_wen  = v.wen;
    req_lock = v.lock;
    g = -1;
    for (int i = 0; i < N_REQ; i++) begin
      if (v.exp[i]) g = i;
      req_adr[i*ADR_W +: ADR_W] = v.exp[i] ? v.adr : (v.adr ^ ADR_W'(10'h3C0 + i));
      req_dat[i*DAT_W +: DAT_W] = v.exp[i] ? v.dat : (v.dat ^ DAT_W'(32'hA5A5_0000 + i));
    end
    #2;
    check("req_rdy", 64'(req_rdy), 64'(v.exp));
    if (g >= 0) begin
      check("bk_wen",   64'(bk_wen),   64'(v.wen[g]));
      check("bk_adr",   64'(bk_adr),   64'(v.adr));
      check("bk_datai", 64'(bk_datai), 64'(v.dat));
      e.due = cyc + RD_LAT;
      e.wr  = v.wen[g];
      e.id  = 2'(g);
      e.dat = v.wen[g] ? '0 : shadow[v.adr];
      if (v.wen[g]) shadow[v.adr] = v.dat;
      sb.push_back(e);
    end else begin
      check("bk_idle_wen", 64'(bk_wen),   64'(0));
      check("bk_idle_adr", 64'(bk_adr),   64'(0));
      check("bk_idle_dat", 64'(bk_datai), 64'(0));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      step(mk(1'b1, 4'h0, 4'h0, 4'h0, '0, '0, 4'h0));
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; arb_en = 1'b1;
    req_vld = '0; req_wen = '0; req_lock = '0; req_adr = '0; req_dat = '0;

    // Idle, then fairness across four writers: grants 0,1,2,3,0,1,2,3.
    tbl.push_back(mk(1'b1, 4'h0, 4'h0, 4'h0, 10'h000, 32'h0, 4'h0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b1, 4'hF, 4'hF, 4'h0, ADR_W'(10'h20 + k), DAT_W'(32'h1000_0000 + k),
                       4'(1 << (k % 4))));
    // Write then read of the same address from different requesters.
    tbl.push_back(mk(1'b1, 4'b0010, 4'b0010, 4'h0, 10'h005, 32'hDEAD_BEEF, 4'b0010));
    tbl.push_back(mk(1'b1, 4'b0100, 4'b0000, 4'h0, 10'h005, 32'h0,         4'b0100));
    tbl.push_back(mk(1'b1, 4'b1000, 4'b0000, 4'h0, 10'h022, 32'h0,         4'b1000));
    // Lock burst capped at MAX_LOCK grants, then rotation resumes past the owner.
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1'b1, 4'b0111, 4'h0, 4'b0001, 10'h021, 32'h0, 4'b0001));
    tbl.push_back(mk(1'b1, 4'b0111, 4'h0, 4'b0001, 10'h023, 32'h0, 4'b0010));
    // Lock taken then dropped because the owner withdraws its request.
    tbl.push_back(mk(1'b1, 4'b0111, 4'h0, 4'b0001, 10'h024, 32'h0, 4'b0100));
    tbl.push_back(mk(1'b1, 4'b0111, 4'h0, 4'b0001, 10'h025, 32'h0, 4'b0001));
    tbl.push_back(mk(1'b1, 4'b0110, 4'h0, 4'b0001, 10'h026, 32'h0, 4'b0010));
    tbl.push_back(mk(1'b1, 4'b0111, 4'h0, 4'b0000, 10'h027, 32'h0, 4'b0100));
    // Stall with a lock held and a read in flight; the stall must also clear the lock.
    tbl.push_back(mk(1'b1, 4'hF, 4'h0, 4'hF, 10'h020, 32'h0, 4'b1000));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b0, 4'hF, 4'h0, 4'hF, 10'h020, 32'h0, 4'b0000));
    tbl.push_back(mk(1'b1, 4'hF, 4'b0001, 4'h0, 10'h003, 32'hCAFE_0003, 4'b0001));
    // Back-to-back reads from requester 3, addresses 0..5.
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(1'b1, 4'b1000, 4'h0, 4'h0, ADR_W'(k), 32'h0, 4'b1000));

    // Reset state.
    #12;
    check("rst_req_rdy", 64'(req_rdy), 64'(0));
    check("rst_rsp_vld", 64'(rsp_vld), 64'(0));
    check("rst_bk_wen",  64'(bk_wen),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) step(tbl[r]);
    drain();

    // Reset mid-traffic: one response lands before reset, the other must be discarded.
    step(mk(1'b1, 4'hF, 4'h0, 4'h0, 10'h021, 32'h0, 4'b0001));
    step(mk(1'b1, 4'hF, 4'h0, 4'h0, 10'h022, 32'h0, 4'b0010));
    @(negedge clk);
    mon_rsp();
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_req_rdy", 64'(req_rdy), 64'(0));
    check("midrst_rsp_vld", 64'(rsp_vld), 64'(0));
    check("midrst_rsp_wr",  64'(rsp_wr),  64'(0));
    check("midrst_rsp_id",  64'(rsp_id),  64'(0));
    check("midrst_rsp_dat", 64'(rsp_dat), 64'(0));
    check("midrst_bk_adr",  64'(bk_adr),  64'(0));
    req_vld = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    step(mk(1'b1, 4'h0, 4'h0, 4'h0, 10'h000, 32'h0, 4'b0000));
    step(mk(1'b1, 4'hF, 4'h0, 4'h0, 10'h024, 32'h0, 4'b0001));
    step(mk(1'b1, 4'hF, 4'h0, 4'h0, 10'h025, 32'h0, 4'b0010));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
